alu_iter: RTL and testbench

ALU_ITER -- requirements
Module: alu_iter

---
 rtl/alu_iter_pkg.sv | 48 ++++
 rtl/alu_iter_if.sv | 16 +
 rtl/alu_muldiv.sv | 75 +++++++
 rtl/alu_ops.v | 30 +++
 rtl/alu_iter.sv | 169 ++++++++++++++++
 tb/tb_alu_iter.sv | 202 ++++++++++++++++++++
 6 files changed

// File: rtl/alu_iter_pkg.sv
// Shared types, opcode constants and flag packing for alu_iter.
`ifndef ALU_OPS_V
`include "alu_ops.v"
`endif

package alu_iter_pkg;

  localparam int OP_W = 6;

  localparam logic [OP_W-1:0] OP_ADD = `ALU_ADD;
  localparam logic [OP_W-1:0] OP_INC = `ALU_INC;
  localparam logic [OP_W-1:0] OP_SUB = `ALU_SUB;
  localparam logic [OP_W-1:0] OP_DEC = `ALU_DEC;
  localparam logic [OP_W-1:0] OP_CMP = `ALU_CMP;
  localparam logic [OP_W-1:0] OP_LSL = `ALU_LSL;
  localparam logic [OP_W-1:0] OP_LSR = `ALU_LSR;
  localparam logic [OP_W-1:0] OP_RSL = `ALU_RSL;
  localparam logic [OP_W-1:0] OP_RSR = `ALU_RSR;
  localparam logic [OP_W-1:0] OP_AND = `ALU_AND;
  localparam logic [OP_W-1:0] OP_OR  = `ALU_OR;
  localparam logic [OP_W-1:0] OP_XOR = `ALU_XOR;
  localparam logic [OP_W-1:0] OP_TST = `ALU_TST;
  localparam logic [OP_W-1:0] OP_NOT = `ALU_NOT;
  localparam logic [OP_W-1:0] OP_MUL = `ALU_MUL;
  localparam logic [OP_W-1:0] OP_DIV = `ALU_DIV;
  localparam logic [OP_W-1:0] OP_MOD = `ALU_MOD;
  localparam logic [OP_W-1:0] OP_NOP = `ALU_NOP;

  localparam int FLAG_Z = `ALU_FLAG_Z;
  localparam int FLAG_N = `ALU_FLAG_N;
  localparam int FLAG_C = `ALU_FLAG_C;
  localparam int FLAG_V = `ALU_FLAG_V;

  typedef enum logic {IDLE, ITER} state_t;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_MOD} md_op_t;

  function automatic logic [3:0] pack_flags(input logic v, input logic c,
                                            input logic n, input logic z);
    logic [3:0] f;
    f = '0;
    f[FLAG_V] = v;
    f[FLAG_C] = c;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    return f;
  endfunction

endpackage

// File: rtl/alu_iter_if.sv
// Request/response bundle between an ALU client and alu_iter.
interface alu_iter_if #(parameter int WIDTH = 16);
    logic             enable;
    logic [5:0]       opcode;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] Result;
    logic [3:0]       flags;

    modport master (output enable, opcode, A, B,
                    input  busy, done, Result, flags);
    modport slave  (input  enable, opcode, A, B,
                    output busy, done, Result, flags);
endinterface

// File: rtl/alu_muldiv.sv
// Iterative unsigned multiplier / restoring divider, one step per clock.
// Product = {rem-side, quo-side}; quotient in the low half, remainder in the high half.
module alu_muldiv
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  md_op_t             op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               last,
    output logic [2*WIDTH-1:0] quo_prod,
    output logic [WIDTH-1:0]   rem
);
    localparam int CNT_W = $clog2(WIDTH);

    logic [CNT_W-1:0] cnt;
    logic             active;
    logic             is_div_p0;
    logic [WIDTH-1:0] hi_p0, lo_p0, opb_p0;
    logic [WIDTH-1:0] hi_nxt, lo_nxt;
    logic [WIDTH:0]   mul_sum, div_sh, div_diff;

    assign mul_sum  = {1'b0, hi_p0} + (lo_p0[0] ? {1'b0, opb_p0} : '0);
    assign div_sh   = {hi_p0, lo_p0[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb_p0};

    // Multiply shifts the running sum down into lo; divide shifts quotient bits up into lo.
    always_comb begin
        hi_nxt = mul_sum[WIDTH:1];
        lo_nxt = {mul_sum[0], lo_p0[WIDTH-1:1]};
        if (is_div_p0) begin
            if (!div_diff[WIDTH]) begin
                hi_nxt = div_diff[WIDTH-1:0];
                lo_nxt = {lo_p0[WIDTH-2:0], 1'b1};
            end else begin
                hi_nxt = div_sh[WIDTH-1:0];
                lo_nxt = {lo_p0[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            active <= 1'b0;
            cnt    <= '0;
        end else if (start) begin
            active <= 1'b1;
            cnt    <= '0;
        end else if (active) begin
            cnt <= cnt + 1'b1;
            if (last) active <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            hi_p0     <= '0;
            lo_p0     <= a;
            opb_p0    <= b;
            is_div_p0 <= (op != MD_MUL);
        end else if (active) begin
            hi_p0 <= hi_nxt;
            lo_p0 <= lo_nxt;
        end
    end

    assign last     = active && (cnt == CNT_W'(WIDTH-1));
    assign quo_prod = is_div_p0 ? {{WIDTH{1'b0}}, lo_nxt} : {hi_nxt, lo_nxt};
    assign rem      = hi_nxt;

endmodule

// File: rtl/alu_ops.v
// Shared opcode encodings and flag bit positions for the ALU family.
// Flags are packed as {V,C,N,Z} = flags[3:0].
`ifndef ALU_OPS_V
`define ALU_OPS_V

`define ALU_ADD 6'd0
`define ALU_INC 6'd1
`define ALU_SUB 6'd2
`define ALU_DEC 6'd3
`define ALU_CMP 6'd4
`define ALU_LSL 6'd5
`define ALU_LSR 6'd6
`define ALU_RSL 6'd7
`define ALU_RSR 6'd8
`define ALU_AND 6'd9
`define ALU_OR  6'd10
`define ALU_XOR 6'd11
`define ALU_TST 6'd12
`define ALU_NOT 6'd13
`define ALU_MUL 6'd14
`define ALU_DIV 6'd15
`define ALU_MOD 6'd16
`define ALU_NOP 6'd17

`define ALU_FLAG_Z 0
`define ALU_FLAG_N 1
`define ALU_FLAG_C 2
`define ALU_FLAG_V 3

`endif

// File: rtl/alu_iter.sv
// Multi-cycle ALU: single-cycle ops complete at acceptance, MUL/DIV/MOD iterate
// for 16 clocks in alu_muldiv before Result/flags are written.
module alu_iter
    import alu_iter_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    alu_iter_if.slave  bus
);
    localparam int SHW = $clog2(WIDTH);

    state_t           state_q;
    logic             busy_q, done_q;
    logic [WIDTH-1:0] result_q;
    logic [3:0]       flags_q;
    md_op_t           md_op_q;

    logic [WIDTH-1:0]   a, b, add_b, sub_b, sc_res, md_val;
    logic [WIDTH:0]     add_sum, sub_diff;
    logic [SHW-1:0]     shamt;
    logic [2*WIDTH-1:0] lsl_ext, lsr_ext, rol_ext, ror_ext, md_qp;
    logic [WIDTH-1:0]   md_rem;
    logic               sc_c, sc_v, wr_res, wr_flg, is_iter, md_start, md_last, md_c;
    logic               b_zero;
    md_op_t             md_op;
    logic [3:0]         sc_flags, md_flags;

    assign a        = bus.A;
    assign b        = bus.B;
    assign b_zero   = (b == '0);
    assign shamt    = b[SHW-1:0];
    assign add_b    = (bus.opcode == OP_INC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign sub_b    = (bus.opcode == OP_DEC) ? {{(WIDTH-1){1'b0}}, 1'b1} : b;
    assign add_sum  = {1'b0, a} + {1'b0, add_b};
    assign sub_diff = {1'b0, a} - {1'b0, sub_b};
    // Shifting into a double-width word leaves the last bit shifted out at the seam.
    assign lsl_ext  = {{WIDTH{1'b0}}, a} << shamt;
    assign lsr_ext  = {a, {WIDTH{1'b0}}} >> shamt;
    assign rol_ext  = {a, a} << shamt;
    assign ror_ext  = {a, a} >> shamt;

    always_comb begin
        sc_res  = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        wr_res  = 1'b0;
        wr_flg  = 1'b0;
        is_iter = 1'b0;
        md_op   = MD_MUL;
        case (bus.opcode)
            OP_ADD, OP_INC: begin
                sc_res = add_sum[WIDTH-1:0];
                sc_c   = add_sum[WIDTH];
                sc_v   = (a[WIDTH-1] == add_b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
                wr_res = 1'b1;
                wr_flg = 1'b1;
            end
            OP_SUB, OP_DEC, OP_CMP: begin
                sc_res = sub_diff[WIDTH-1:0];
                sc_c   = sub_diff[WIDTH];
                sc_v   = (a[WIDTH-1] != sub_b[WIDTH-1]) && (sc_res[WIDTH-1] != a[WIDTH-1]);
                wr_res = (bus.opcode != OP_CMP);
                wr_flg = 1'b1;
            end
            OP_LSL: begin
                sc_res = lsl_ext[WIDTH-1:0];
                sc_c   = lsl_ext[WIDTH];
                wr_res = 1'b1;
                wr_flg = 1'b1;
            end
            OP_LSR: begin
                sc_res = lsr_ext[2*WIDTH-1:WIDTH];
                sc_c   = lsr_ext[WIDTH-1];
                wr_res = 1'b1;
                wr_flg = 1'b1;
            end
            OP_RSL, OP_RSR: begin
                sc_res = (bus.opcode == OP_RSL) ? rol_ext[2*WIDTH-1:WIDTH] : ror_ext[WIDTH-1:0];
                wr_res = 1'b1;
                wr_flg = 1'b1;
            end
            OP_AND, OP_TST, OP_OR, OP_XOR, OP_NOT: begin
                case (bus.opcode)
                    OP_OR:   sc_res = a | b;
                    OP_XOR:  sc_res = a ^ b;
                    OP_NOT:  sc_res = ~a;
                    default: sc_res = a & b;
                endcase
                wr_res = (bus.opcode != OP_TST);
                wr_flg = 1'b1;
            end
            OP_MUL: is_iter = 1'b1;
            OP_DIV, OP_MOD: begin
                // Divide-by-zero completes immediately with V set.
                if (b_zero) begin
                    sc_res = (bus.opcode == OP_DIV) ? {WIDTH{1'b1}} : a;
                    sc_v   = 1'b1;
                    wr_res = 1'b1;
                    wr_flg = 1'b1;
                end else begin
                    is_iter = 1'b1;
                    md_op   = (bus.opcode == OP_DIV) ? MD_DIV : MD_MOD;
                end
            end
            OP_NOP:  ;
            default: ;
        endcase
    end

    assign sc_flags = pack_flags(sc_v, sc_c, sc_res[WIDTH-1], sc_res == '0);
    assign md_start = (state_q == IDLE) && bus.enable && is_iter;

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .start    (md_start),
        .op       (md_op),
        .a        (a),
        .b        (b),
        .last     (md_last),
        .quo_prod (md_qp),
        .rem      (md_rem)
    );

    assign md_val   = (md_op_q == MD_MOD) ? md_rem : md_qp[WIDTH-1:0];
    assign md_c     = (md_op_q == MD_MUL) && (md_qp[2*WIDTH-1:WIDTH] != '0);
    assign md_flags = pack_flags(1'b0, md_c, md_val[WIDTH-1], md_val == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.enable) begin
                    if (is_iter) begin
                        state_q <= ITER;
                        busy_q  <= 1'b1;
                        md_op_q <= md_op;
                    end else begin
                        done_q <= 1'b1;
                        if (wr_res) result_q <= sc_res;
                        if (wr_flg) flags_q  <= sc_flags;
                    end
                end
                ITER: if (md_last) begin
                    state_q  <= IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    result_q <= md_val;
                    flags_q  <= md_flags;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.Result = result_q;
    assign bus.flags  = flags_q;

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter; flags are compared as {V,C,N,Z}.
module tb_alu_iter;
    import alu_iter_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_iter_if #(.WIDTH(16)) bus ();
    alu_iter #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int checks = 0;
    int failures = 0;

    task automatic drive(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.enable = 1'b1; bus.opcode = op; bus.A = a; bus.B = b;
    endtask

    // Issue one request; returns at the falling edge after the acceptance edge.
    task automatic single(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        drive(op, a, b);
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    // n = edges after acceptance until done is seen, bounded at 40.
    task automatic wait_done(output int n, output int busy_hi);
        n = 0; busy_hi = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (bus.busy === 1'b1) busy_hi++;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drive(OP_ADD, 16'd1, 16'd1);
        repeat (2) @(negedge clk);
        if (bus.busy !== 1'b0) begin $display("FAIL rst_busy got=%b exp=0", bus.busy); failures++; end checks++;
        if (bus.done !== 1'b0) begin $display("FAIL rst_done got=%b exp=0", bus.done); failures++; end checks++;
        if (bus.Result !== 16'h0000) begin $display("FAIL rst_result got=%h exp=0000", bus.Result); failures++; end checks++;
        if (bus.flags !== 4'h0) begin $display("FAIL rst_flags got=%h exp=0", bus.flags); failures++; end checks++;
        rst = 1'b0;
        bus.enable = 1'b0;
        @(negedge clk);
        if (bus.done !== 1'b0) begin $display("FAIL rst_req_ignored got=%b exp=0", bus.done); failures++; end checks++;
    endtask

    task automatic test_add_sub;
        single(OP_ADD, 16'd10, 16'd1);
        if (bus.done !== 1'b1) begin $display("FAIL add_done got=%b exp=1", bus.done); failures++; end checks++;
        if (bus.Result !== 16'd11) begin $display("FAIL add_result got=%h exp=000b", bus.Result); failures++; end checks++;
        if (bus.flags !== 4'b0000) begin $display("FAIL add_flags got=%b exp=0000", bus.flags); failures++; end checks++;
        @(negedge clk);
        if (bus.done !== 1'b0) begin $display("FAIL add_done_pulse got=%b exp=0", bus.done); failures++; end checks++;
        single(OP_SUB, 16'd1, 16'd2);
        if (bus.Result !== 16'hFFFF) begin $display("FAIL sub_result got=%h exp=ffff", bus.Result); failures++; end checks++;
        if (bus.flags !== 4'b0110) begin $display("FAIL sub_flags got=%b exp=0110", bus.flags); failures++; end checks++;
        single(OP_CMP, 16'd5, 16'd5);
        if (bus.done !== 1'b1) begin $display("FAIL cmp_done got=%b exp=1", bus.done); failures++; end checks++;
        if (bus.Result !== 16'hFFFF) begin $display("FAIL cmp_result_held got=%h exp=ffff", bus.Result); failures++; end checks++;
        if (bus.flags !== 4'b0001) begin $display("FAIL cmp_flags got=%b exp=0001", bus.flags); failures++; end checks++;
        single(OP_ADD, 16'h7FFF, 16'h0001);
        if ({bus.Result, bus.flags} !== {16'h8000, 4'b1010}) begin $display("FAIL add_ovf got=%h/%b exp=8000/1010", bus.Result, bus.flags); failures++; end checks++;
        single(OP_DEC, 16'h0000, 16'h1234);
        if ({bus.Result, bus.flags} !== {16'hFFFF, 4'b0110}) begin $display("FAIL dec got=%h/%b exp=ffff/0110", bus.Result, bus.flags); failures++; end checks++;
        single(OP_SUB, 16'h8000, 16'h0001);
        if ({bus.Result, bus.flags} !== {16'h7FFF, 4'b1000}) begin $display("FAIL sub_ovf got=%h/%b exp=7fff/1000", bus.Result, bus.flags); failures++; end checks++;
    endtask

    task automatic test_shift_logic;
        single(OP_LSL, 16'h8001, 16'd1);
        if ({bus.Result, bus.flags} !== {16'h0002, 4'b0100}) begin $display("FAIL lsl got=%h/%b exp=0002/0100", bus.Result, bus.flags); failures++; end checks++;
        single(OP_LSL, 16'h8000, 16'd0);
        if ({bus.Result, bus.flags} !== {16'h8000, 4'b0010}) begin $display("FAIL lsl0 got=%h/%b exp=8000/0010", bus.Result, bus.flags); failures++; end checks++;
        single(OP_LSR, 16'h0003, 16'd1);
        if ({bus.Result, bus.flags} !== {16'h0001, 4'b0100}) begin $display("FAIL lsr got=%h/%b exp=0001/0100", bus.Result, bus.flags); failures++; end checks++;
        single(OP_RSL, 16'h8001, 16'd4);
        if ({bus.Result, bus.flags} !== {16'h0018, 4'b0000}) begin $display("FAIL rsl got=%h/%b exp=0018/0000", bus.Result, bus.flags); failures++; end checks++;
        single(OP_RSR, 16'h0001, 16'd1);
        if ({bus.Result, bus.flags} !== {16'h8000, 4'b0010}) begin $display("FAIL rsr got=%h/%b exp=8000/0010", bus.Result, bus.flags); failures++; end checks++;
        single(OP_XOR, 16'hF0F0, 16'hFF00);
        if ({bus.Result, bus.flags} !== {16'h0FF0, 4'b0000}) begin $display("FAIL xor got=%h/%b exp=0ff0/0000", bus.Result, bus.flags); failures++; end checks++;
        single(OP_TST, 16'h00FF, 16'hFF00);
        if ({bus.Result, bus.flags} !== {16'h0FF0, 4'b0001}) begin $display("FAIL tst got=%h/%b exp=0ff0/0001", bus.Result, bus.flags); failures++; end checks++;
        single(OP_NOT, 16'h0000, 16'h0000);
        if ({bus.Result, bus.flags} !== {16'hFFFF, 4'b0010}) begin $display("FAIL not got=%h/%b exp=ffff/0010", bus.Result, bus.flags); failures++; end checks++;
        single(OP_NOP, 16'h1234, 16'h5678);
        if ({bus.done, bus.Result, bus.flags} !== {1'b1, 16'hFFFF, 4'b0010}) begin $display("FAIL nop got=%b/%h/%b exp=1/ffff/0010", bus.done, bus.Result, bus.flags); failures++; end checks++;
    endtask

    task automatic test_mul;
        int n, bh;
        single(OP_MUL, 16'd300, 16'd300);
        wait_done(n, bh);
        if (n !== 16) begin $display("FAIL mul_latency got=%0d exp=16", n); failures++; end checks++;
        if (bh !== 16) begin $display("FAIL mul_busy_cycles got=%0d exp=16", bh); failures++; end checks++;
        if (bus.busy !== 1'b0) begin $display("FAIL mul_busy_at_done got=%b exp=0", bus.busy); failures++; end checks++;
        if ({bus.Result, bus.flags} !== {16'h5F90, 4'b0100}) begin $display("FAIL mul got=%h/%b exp=5f90/0100", bus.Result, bus.flags); failures++; end checks++;
        drive(OP_ADD, 16'd2, 16'd3);
        @(negedge clk);
        bus.enable = 1'b0;
        if ({bus.done, bus.Result} !== {1'b1, 16'd5}) begin $display("FAIL accept_in_done got=%b/%h exp=1/0005", bus.done, bus.Result); failures++; end checks++;
        single(OP_MUL, 16'd7, 16'd6);
        wait_done(n, bh);
        if ({bus.Result, bus.flags} !== {16'd42, 4'b0000}) begin $display("FAIL mul_small got=%h/%b exp=002a/0000", bus.Result, bus.flags); failures++; end checks++;
    endtask

    task automatic test_div_mod;
        int n, bh;
        single(OP_DIV, 16'd10, 16'd3);
        wait_done(n, bh);
        if (n !== 16) begin $display("FAIL div_latency got=%0d exp=16", n); failures++; end checks++;
        if ({bus.Result, bus.flags} !== {16'd3, 4'b0000}) begin $display("FAIL div got=%h/%b exp=0003/0000", bus.Result, bus.flags); failures++; end checks++;
        single(OP_MOD, 16'd10, 16'd3);
        wait_done(n, bh);
        if ({bus.Result, bus.flags} !== {16'd1, 4'b0000}) begin $display("FAIL mod got=%h/%b exp=0001/0000", bus.Result, bus.flags); failures++; end checks++;
        single(OP_DIV, 16'hFFFF, 16'h0010);
        wait_done(n, bh);
        if (bus.Result !== 16'h0FFF) begin $display("FAIL div_big got=%h exp=0fff", bus.Result); failures++; end checks++;
        single(OP_DIV, 16'd7, 16'd0);
        if ({bus.done, bus.busy} !== 2'b10) begin $display("FAIL div0_done_busy got=%b exp=10", {bus.done, bus.busy}); failures++; end checks++;
        if ({bus.Result, bus.flags} !== {16'hFFFF, 4'b1010}) begin $display("FAIL div0 got=%h/%b exp=ffff/1010", bus.Result, bus.flags); failures++; end checks++;
        single(OP_MOD, 16'd7, 16'd0);
        if ({bus.done, bus.Result, bus.flags} !== {1'b1, 16'd7, 4'b1000}) begin $display("FAIL mod0 got=%b/%h/%b exp=1/0007/1000", bus.done, bus.Result, bus.flags); failures++; end checks++;
    endtask

    task automatic test_busy_ignore;
        int n, dones;
        single(OP_DIV, 16'd10, 16'd3);
        n = 0;
        while (bus.done !== 1'b1 && n < 40) begin
            if (n == 4) drive(OP_ADD, 16'd1, 16'd1);
            else bus.enable = 1'b0;
            @(negedge clk);
            n++;
        end
        bus.enable = 1'b0;
        if (n !== 16) begin $display("FAIL ignore_latency got=%0d exp=16", n); failures++; end checks++;
        if (bus.Result !== 16'd3) begin $display("FAIL ignore_result got=%h exp=0003", bus.Result); failures++; end checks++;
        dones = 0;
        repeat (4) begin @(negedge clk); if (bus.done === 1'b1) dones++; end
        if (dones !== 0) begin $display("FAIL ignore_extra_done got=%0d exp=0", dones); failures++; end checks++;
    endtask

    task automatic test_rst_mid;
        int n, dones;
        single(OP_DIV, 16'd10, 16'd3);
        n = 0;
        while (n < 8) begin @(negedge clk); n++; end
        rst = 1'b1;
        @(negedge clk);
        if ({bus.busy, bus.done} !== 2'b00) begin $display("FAIL midrst_busy_done got=%b exp=00", {bus.busy, bus.done}); failures++; end checks++;
        if ({bus.Result, bus.flags} !== {16'h0000, 4'h0}) begin $display("FAIL midrst_regs got=%h/%b exp=0000/0000", bus.Result, bus.flags); failures++; end checks++;
        rst = 1'b0;
        dones = 0;
        repeat (20) begin @(negedge clk); if (bus.done === 1'b1 || bus.busy === 1'b1) dones++; end
        if (dones !== 0) begin $display("FAIL midrst_no_done got=%0d exp=0", dones); failures++; end checks++;
        single(OP_INC, 16'hFFFF, 16'h0000);
        if ({bus.done, bus.Result, bus.flags} !== {1'b1, 16'h0000, 4'b0101}) begin $display("FAIL inc_after_rst got=%b/%h/%b exp=1/0000/0101", bus.done, bus.Result, bus.flags); failures++; end checks++;
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        drive(OP_ADD, 16'd1, 16'd2);
        @(negedge clk);
        if ({bus.done, bus.Result} !== {1'b1, 16'd3}) begin $display("FAIL b2b_0 got=%b/%h exp=1/0003", bus.done, bus.Result); failures++; end checks++;
        drive(OP_ADD, 16'd3, 16'd4);
        @(negedge clk);
        if ({bus.done, bus.Result} !== {1'b1, 16'd7}) begin $display("FAIL b2b_1 got=%b/%h exp=1/0007", bus.done, bus.Result); failures++; end checks++;
        drive(OP_SUB, 16'd5, 16'd1);
        @(negedge clk);
        if ({bus.done, bus.Result} !== {1'b1, 16'd4}) begin $display("FAIL b2b_2 got=%b/%h exp=1/0004", bus.done, bus.Result); failures++; end checks++;
        bus.enable = 1'b0;
        @(negedge clk);
        if (bus.done !== 1'b0) begin $display("FAIL b2b_end got=%b exp=0", bus.done); failures++; end checks++;
    endtask

    initial begin
        bus.enable = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;
        rst = 1'b1;
        test_reset();
        test_add_sub();
        test_shift_logic();
        test_mul();
        test_div_mod();
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
